// File: rtl/bp_sacc_io_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_sacc_io_initiator -- runs one dot-product job on a BedRock-IO accelerator:
// CSR writes, start, status polling, SPM read-back. Option: BP_SACC_POLL_TIMEOUT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
package bp_sacc_io_pkg;
   typedef enum logic [1:0] { e_bp_default_cfg = 2'd0 } bp_params_e;

   localparam int dword_width_gp = 64;
   localparam int paddr_width_gp = 40;

   localparam logic [3:0] e_bedrock_mem_uc_rd  = 4'd2;
   localparam logic [3:0] e_bedrock_mem_uc_wr  = 4'd3;
   localparam logic [2:0] e_bedrock_msg_size_8 = 3'd3;

   function automatic int lce_id_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 4;
         default:          return 4;
      endcase
   endfunction
endpackage

module bp_sacc_io_initiator
   import bp_sacc_io_pkg::*;
#(
   parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
   parameter logic [39:0] cfg_base_p     = '0,
   parameter logic [39:0] spm_base_p     = '0,
   parameter int          poll_timeout_p = 1024,
   localparam int lce_id_width_p       = lce_id_width_f(bp_params_p),
   localparam int cce_mem_msg_width_lp = dword_width_gp + lce_id_width_p + paddr_width_gp + 7
)(
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [lce_id_width_p-1:0]       lce_id_i,
   input  logic                            job_v_i,
   output logic                            job_ready_o,
   input  logic [63:0]                     job_a_ptr_i,
   input  logic [63:0]                     job_b_ptr_i,
   input  logic [63:0]                     job_res_ptr_i,
   input  logic [63:0]                     job_len_i,
   output logic                            done_v_o,
   output logic [63:0]                     result_o,
   output logic                            error_o,
   output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
   output logic                            io_cmd_v_o,
   input  logic                            io_cmd_ready_i,
   input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
   input  logic                            io_resp_v_i,
   output logic                            io_resp_yumi_o
);
   localparam int hdr_width_lp = cce_mem_msg_width_lp - dword_width_gp;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_A     = 4'd1;
   localparam logic [3:0] S_WR_B     = 4'd2;
   localparam logic [3:0] S_WR_LEN   = 4'd3;
   localparam logic [3:0] S_WR_RES   = 4'd4;
   localparam logic [3:0] S_WR_START = 4'd5;
   localparam logic [3:0] S_GAP      = 4'd6;
   localparam logic [3:0] S_POLL     = 4'd7;
   localparam logic [3:0] S_RD_RES   = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   logic [3:0]  state_q, state_d;
   logic        wait_q, wait_d;
   logic [63:0] a_q, a_d, b_q, b_d, len_q, len_d, res_q, res_d, result_q, result_d;
   logic        err_q, err_d, gap_q, gap_d;
   logic [31:0] poll_cnt_q, poll_cnt_d;

   logic [63:0] resp_data;
   logic        cmd_state;
   logic [3:0]  cmd_type;
   logic [39:0] cmd_addr;
   logic [63:0] cmd_data;
   logic        unused_resp_hdr;

   assign resp_data       = io_resp_i[cce_mem_msg_width_lp-1 -: dword_width_gp];
   assign unused_resp_hdr = ^{io_resp_i[hdr_width_lp-1:0], poll_timeout_p != 0};
   assign result_o        = result_q;
   assign cmd_state       = (state_q inside {S_WR_A, S_WR_B, S_WR_LEN, S_WR_RES,
                                             S_WR_START, S_POLL, S_RD_RES});

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         wait_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         len_q      <= '0;
         res_q      <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         gap_q      <= 1'b0;
         poll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         a_q        <= a_d;
         b_q        <= b_d;
         len_q      <= len_d;
         res_q      <= res_d;
         result_q   <= result_d;
         err_q      <= err_d;
         gap_q      <= gap_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      a_d        = a_q;
      b_d        = b_q;
      len_d      = len_q;
      res_d      = res_q;
      result_d   = result_q;
      err_d      = err_q;
      gap_d      = gap_q;
      poll_cnt_d = poll_cnt_q;
      case (state_q)
         S_IDLE: if (job_v_i) begin
            a_d    = job_a_ptr_i;
            b_d    = job_b_ptr_i;
            len_d  = job_len_i;
            res_d  = job_res_ptr_i;
            wait_d = 1'b0;
            err_d  = (job_len_i == 64'd0) || (job_len_i > 64'd8);
            state_d = err_d ? S_DONE : S_WR_A;
         end
         S_WR_A, S_WR_B, S_WR_LEN, S_WR_RES, S_WR_START, S_POLL, S_RD_RES: begin
            if (!wait_q) begin
               wait_d = io_cmd_ready_i;
            end else if (io_resp_v_i) begin
               wait_d = 1'b0;
               case (state_q)
                  S_WR_A:     state_d = S_WR_B;
                  S_WR_B:     state_d = S_WR_LEN;
                  S_WR_LEN:   state_d = S_WR_RES;
                  S_WR_RES:   state_d = S_WR_START;
                  S_WR_START: begin
                     state_d = S_GAP;
                     gap_d   = 1'b0;
                  end
                  S_POLL: begin
                     // A zero status simply stays in POLL, which reissues the read next cycle.
                     if (resp_data != 64'd0) begin
                        state_d = S_RD_RES;
                     end
`ifdef BP_SACC_POLL_TIMEOUT_EN
                     else if (poll_cnt_q == 32'(poll_timeout_p - 1)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                     end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                     end
`endif
                  end
                  S_RD_RES: begin
                     result_d = resp_data;
                     state_d  = S_DONE;
                  end
                  default: ;
               endcase
            end
         end
         S_GAP: begin
            if (gap_q) begin
               state_d    = S_POLL;
               poll_cnt_d = '0;
            end else begin
               gap_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      job_ready_o    = 1'b0;
      done_v_o       = 1'b0;
      error_o        = 1'b0;
      cmd_type       = e_bedrock_mem_uc_wr;
      cmd_addr       = '0;
      cmd_data       = '0;
      case (state_q)
         S_IDLE:     job_ready_o = 1'b1;
         S_WR_A:     begin cmd_addr = cfg_base_p + 40'h000; cmd_data = a_q;   end
         S_WR_B:     begin cmd_addr = cfg_base_p + 40'h040; cmd_data = b_q;   end
         S_WR_LEN:   begin cmd_addr = cfg_base_p + 40'h080; cmd_data = len_q; end
         S_WR_RES:   begin cmd_addr = cfg_base_p + 40'h140; cmd_data = res_q; end
         S_WR_START: begin cmd_addr = cfg_base_p + 40'h0c0; cmd_data = 64'd1; end
         S_POLL: begin
            cmd_type = e_bedrock_mem_uc_rd;
            cmd_addr = cfg_base_p + 40'h100;
         end
         S_RD_RES: begin
            cmd_type = e_bedrock_mem_uc_rd;
            cmd_addr = spm_base_p + res_q[39:0];
         end
         S_DONE: begin
            done_v_o = 1'b1;
            error_o  = err_q;
         end
         default: ;
      endcase
      io_cmd_v_o     = cmd_state & ~wait_q;
      io_resp_yumi_o = cmd_state & wait_q & io_resp_v_i;
      io_cmd_o       = {cmd_data, lce_id_i, cmd_addr, e_bedrock_msg_size_8, cmd_type};
   end
endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_io_initiator.sv
`default_nettype none
// tb_bp_sacc_io_initiator -- scoreboarded bench with a responder modelling the
// accelerator CSRs, status register and SPM.
module tb_bp_sacc_io_initiator;
   import bp_sacc_io_pkg::*;

   localparam int LCE_W = lce_id_width_f(e_bp_default_cfg);
   localparam int MSG_W = dword_width_gp + LCE_W + paddr_width_gp + 7;
   localparam logic [39:0] CFG = 40'h10_0000;
   localparam logic [39:0] SPM = 40'h20_0000;
   localparam logic [LCE_W-1:0] LCE_ID = LCE_W'(5);
`ifdef BP_SACC_POLL_TIMEOUT_EN
   localparam int TMO = 4;
   localparam int ZERO_POLLS = 3;
`else
   localparam int TMO = 1024;
   localparam int ZERO_POLLS = 5;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             job_v = 1'b0;
   logic             job_ready;
   logic [63:0]      job_a = '0, job_b = '0, job_res = '0, job_len = '0;
   logic             done_v, error;
   logic [63:0]      result;
   logic [MSG_W-1:0] io_cmd;
   logic             io_cmd_v;
   logic             io_cmd_ready = 1'b0;
   logic [MSG_W-1:0] io_resp = '0;
   logic             io_resp_v = 1'b0;
   logic             io_resp_yumi;

   typedef struct { logic [MSG_W-1:0] msg; string name; } exp_t;
   exp_t        exp_q[$];
   logic [63:0] spm [logic [39:0]];
   logic [63:0] m_a, m_b, m_len, m_res;
   int          polls_left, zero_polls, stall_left;
   int          tests = 0, fails = 0;

   bp_sacc_io_initiator #(
      .bp_params_p(e_bp_default_cfg), .cfg_base_p(CFG), .spm_base_p(SPM), .poll_timeout_p(TMO)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(LCE_ID),
      .job_v_i(job_v), .job_ready_o(job_ready),
      .job_a_ptr_i(job_a), .job_b_ptr_i(job_b), .job_res_ptr_i(job_res), .job_len_i(job_len),
      .done_v_o(done_v), .result_o(result), .error_o(error),
      .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_cmd_ready),
      .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_resp_yumi)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [39:0] addr,
                                          input logic [63:0] d);
      return {d, LCE_ID, addr, e_bedrock_msg_size_8, t};
   endfunction

   task automatic push(input logic [3:0] t, input logic [39:0] addr, input logic [63:0] d,
                       input string name);
      exp_t e;
      e.msg = mk(t, addr, d);
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic push_writes(input logic [63:0] a, b, len, res);
      push(e_bedrock_mem_uc_wr, CFG + 40'h000, a,     "wr_a");
      push(e_bedrock_mem_uc_wr, CFG + 40'h040, b,     "wr_b");
      push(e_bedrock_mem_uc_wr, CFG + 40'h080, len,   "wr_len");
      push(e_bedrock_mem_uc_wr, CFG + 40'h140, res,   "wr_res");
      push(e_bedrock_mem_uc_wr, CFG + 40'h0c0, 64'd1, "wr_start");
   endtask

   task automatic push_polls(input int n);
      for (int i = 0; i < n; i++) push(e_bedrock_mem_uc_rd, CFG + 40'h100, 64'd0, "poll");
   endtask

   // Accelerator model: latch CSRs, compute on start, report busy for zero_polls reads.
   task automatic model(input logic [MSG_W-1:0] m, output logic [63:0] data);
      logic [3:0]  t;
      logic [39:0] addr;
      logic [63:0] d, acc;
      t    = m[3:0];
      addr = m[7 +: 40];
      d    = m[MSG_W-1 -: 64];
      data = '0;
      if (t == e_bedrock_mem_uc_wr) begin
         case (addr - CFG)
            40'h000: m_a = d;
            40'h040: m_b = d;
            40'h080: m_len = d;
            40'h140: m_res = d;
            40'h0c0: begin
               acc = '0;
               for (int i = 0; i < int'(m_len); i++)
                  acc += spm[40'(m_a) + 40'(8*i)] * spm[40'(m_b) + 40'(8*i)];
               spm[40'(m_res)] = acc;
               polls_left = zero_polls;
            end
            default: ;
         endcase
      end else if (addr == CFG + 40'h100) begin
         if (polls_left > 0) begin
            polls_left--;
            data = 64'd0;
         end else begin
            data = 64'd1;
         end
      end else if (spm.exists(addr - SPM)) begin
         data = spm[addr - SPM];
      end
   endtask

   task automatic start_job(input logic [63:0] a, b, len, res);
      @(negedge clk);
      job_a = a; job_b = b; job_len = len; job_res = res; job_v = 1'b1;
      #1;
      tests++;
      if (job_ready !== 1'b1) begin
         fails++;
         $display("FAIL job_ready_at_accept: got %b want 1", job_ready);
      end
      @(posedge clk);
      #1;
      job_v = 1'b0;
      job_a = {$urandom, $urandom}; job_b = {$urandom, $urandom};
      job_res = {$urandom, $urandom}; job_len = 64'($urandom_range(1, 8));
   endtask

   task automatic serve(input int budget, input bit stop_after_poll, input bit jam,
                        output bit got_done, output int cycles, output int first_cmd,
                        output logic [63:0] res, output logic err);
      bit               pend = 1'b0, holding = 1'b0, stop_now = 1'b0;
      logic [63:0]      pdata = '0;
      logic [MSG_W-1:0] held = '0;
      int               proto_err = 0;
      exp_t             e;
      got_done = 1'b0; cycles = 0; first_cmd = 0; res = '0; err = 1'b0;
      while (!got_done && !stop_now && cycles < budget) begin
         @(negedge clk);
         cycles++;
         io_resp_v = pend;
         io_resp = {pdata, {(MSG_W-64){1'b0}}};
         pend = 1'b0;
         io_cmd_ready = 1'b0;
         #1;
         if (io_resp_v && io_resp_yumi !== 1'b1) proto_err++;
         if (done_v === 1'b1) begin
            got_done = 1'b1; res = result; err = error; job_v = 1'b0;
         end else if (job_ready !== 1'b0) begin
            proto_err++;
         end
         if (jam && !got_done) job_v = 1'b1;
         if (io_cmd_v === 1'b1) begin
            if (first_cmd == 0) first_cmd = cycles;
            if (holding) begin
               tests++;
               if (io_cmd !== held) begin
                  fails++;
                  $display("FAIL cmd_stable: got %h want %h", io_cmd, held);
               end
            end
            if (stall_left > 0 && io_cmd[7 +: 40] == CFG + 40'h040) begin
               stall_left--;
               held = io_cmd;
               holding = 1'b1;
            end else begin
               holding = 1'b0;
               io_cmd_ready = 1'b1;
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_cmd: got %h want none", io_cmd);
               end else begin
                  e = exp_q.pop_front();
                  if (io_cmd !== e.msg) begin
                     fails++;
                     $display("FAIL cmd_%s: got %h want %h", e.name, io_cmd, e.msg);
                  end
               end
               model(io_cmd, pdata);
               pend = 1'b1;
               if (stop_after_poll && io_cmd[7 +: 40] == CFG + 40'h100) stop_now = 1'b1;
            end
         end
      end
      if (stop_now) begin
         @(posedge clk);
         #1;
      end
      io_cmd_ready = 1'b0;
      io_resp_v = 1'b0;
      job_v = 1'b0;
      tests++;
      if (proto_err != 0) begin
         fails++;
         $display("FAIL protocol: got %0d yumi/job_ready violations want 0", proto_err);
      end
   endtask

   task automatic check_job(input string name, input bit got_done, input logic [63:0] res,
                            input logic err, input logic [63:0] want_res, input logic want_err);
      tests++;
      if (!got_done) begin
         fails++;
         $display("FAIL %s_done: got no done_v_o want done within budget", name);
      end
      tests++;
      if (err !== want_err) begin
         fails++;
         $display("FAIL %s_error: got %b want %b", name, err, want_err);
      end
      tests++;
      if (res !== want_res) begin
         fails++;
         $display("FAIL %s_result: got %0d want %0d", name, res, want_res);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_cmds_left: got %0d pending want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      io_resp_v = 1'b1;
      #1;
      tests++;
      if ({io_cmd_v, io_resp_yumi, done_v, error} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0000", {io_cmd_v, io_resp_yumi, done_v, error});
      end
      tests++;
      if (result !== 64'd0) begin
         fails++;
         $display("FAIL reset_result: got %h want 0", result);
      end
      io_resp_v = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (job_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_job_ready: got %b want 1", job_ready);
      end
   endtask

   task automatic test_basic();
      bit g; int c, f; logic [63:0] r; logic e;
      zero_polls = 0;
      push_writes(64'h0, 64'h40, 64'd8, 64'h80);
      push_polls(1);
      push(e_bedrock_mem_uc_rd, SPM + 40'h80, 64'd0, "rd_res");
      start_job(64'h0, 64'h40, 64'd8, 64'h80);
      serve(200, 1'b0, 1'b0, g, c, f, r, e);
      tests++;
      if (f != 1) begin
         fails++;
         $display("FAIL basic_latency: got %0d cycles want 1", f);
      end
      check_job("basic", g, r, e, 64'd204, 1'b0);
   endtask

   task automatic test_cmd_stall();
      bit g; int c, f; logic [63:0] r; logic e;
      zero_polls = 0;
      stall_left = 3;
      push_writes(64'h0, 64'h40, 64'd4, 64'h90);
      push_polls(1);
      push(e_bedrock_mem_uc_rd, SPM + 40'h90, 64'd0, "rd_res");
      start_job(64'h0, 64'h40, 64'd4, 64'h90);
      serve(200, 1'b0, 1'b1, g, c, f, r, e);
      tests++;
      if (stall_left != 0) begin
         fails++;
         $display("FAIL stall_applied: got %0d stalls left want 0", stall_left);
      end
      check_job("stall", g, r, e, 64'd30, 1'b0);
   endtask

   task automatic test_bad_len();
      bit g; int c, f; logic [63:0] r; logic e;
      logic [63:0] lens [2];
      lens[0] = 64'd0;
      lens[1] = 64'd9;
      for (int i = 0; i < 2; i++) begin
         start_job(64'h0, 64'h40, lens[i], 64'h80);
         serve(10, 1'b0, 1'b0, g, c, f, r, e);
         tests++;
         if (!g || c != 1 || e !== 1'b1 || f != 0) begin
            fails++;
            $display("FAIL bad_len_%0d: got done=%b cycle=%0d err=%b cmd_cycle=%0d want 1/1/1/0",
                     lens[i], g, c, e, f);
         end
      end
   endtask

   task automatic test_poll();
      bit g; int c, f; logic [63:0] r; logic e;
      zero_polls = ZERO_POLLS;
      push_writes(64'h0, 64'h40, 64'd8, 64'h98);
      push_polls(ZERO_POLLS + 1);
      push(e_bedrock_mem_uc_rd, SPM + 40'h98, 64'd0, "rd_res");
      start_job(64'h0, 64'h40, 64'd8, 64'h98);
      serve(400, 1'b0, 1'b0, g, c, f, r, e);
      check_job("poll", g, r, e, 64'd204, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit g; int c, f; logic [63:0] r; logic e;
      bit saw_done = 1'b0;
      zero_polls = 100;
      push_writes(64'h0, 64'h40, 64'd8, 64'h80);
      push_polls(1);
      start_job(64'h0, 64'h40, 64'd8, 64'h80);
      serve(200, 1'b1, 1'b0, g, c, f, r, e);
      io_resp_v = 1'b1;
      #1;
      tests++;
      if (io_resp_yumi !== 1'b1) begin
         fails++;
         $display("FAIL mid_in_poll_wait: got yumi %b want 1", io_resp_yumi);
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({io_cmd_v, io_resp_yumi, done_v, error} !== 4'b0000 || result !== 64'd0) begin
         fails++;
         $display("FAIL mid_reset_outputs: got ctrl %b result %h want 0000 / 0",
                  {io_cmd_v, io_resp_yumi, done_v, error}, result);
      end
      io_resp_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done_v !== 1'b0) saw_done = 1'b1;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done_v !== 1'b0) saw_done = 1'b1;
      end
      tests++;
      if (saw_done || job_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_after_reset: got done_seen %b job_ready %b want 0 / 1", saw_done, job_ready);
      end
      exp_q.delete();
      zero_polls = 1;
      push_writes(64'h0, 64'h40, 64'd3, 64'ha0);
      push_polls(2);
      push(e_bedrock_mem_uc_rd, SPM + 40'ha0, 64'd0, "rd_res");
      start_job(64'h0, 64'h40, 64'd3, 64'ha0);
      serve(200, 1'b0, 1'b0, g, c, f, r, e);
      check_job("post_reset", g, r, e, 64'd14, 1'b0);
   endtask

`ifdef BP_SACC_POLL_TIMEOUT_EN
   task automatic test_timeout();
      bit g; int c, f; logic [63:0] r; logic e;
      zero_polls = 100;
      push_writes(64'h0, 64'h40, 64'd8, 64'h80);
      push_polls(TMO);
      start_job(64'h0, 64'h40, 64'd8, 64'h80);
      serve(400, 1'b0, 1'b0, g, c, f, r, e);
      check_job("timeout", g, r, e, 64'd14, 1'b1);
   endtask
`endif

   initial begin
      stall_left = 0;
      zero_polls = 0;
      polls_left = 0;
      for (int i = 0; i < 8; i++) begin
         spm[40'(8*i)]         = 64'(i + 1);
         spm[40'h40 + 40'(8*i)] = 64'(i + 1);
      end
      test_reset();
      test_basic();
      test_cmd_stall();
      test_bad_len();
      test_poll();
      test_reset_mid();
`ifdef BP_SACC_POLL_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
